// File: rtl/mgt_01_i_wb_arbiter.sv
// Integer writeback arbiter with a pending-write scoreboard.
// Several execution units compete for the single register-file write port.
// A round-robin arbiter grants at most one requester per cycle. The accepted
// result is registered onto the write port with one cycle of latency.
// The busy vector tracks destinations that have been issued but not yet
// written back.
module mgt_01_i_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int NREG  = 32,
    parameter int DW    = 32,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [N_REQ*AW-1:0]   req_addr_i,
    input  logic [N_REQ*DW-1:0]   req_data_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic                  issue_valid_i,
    input  logic [AW-1:0]         issue_rd_i,
    output logic                  we_o,
    output logic [AW-1:0]         w_iaddr_o,
    output logic [DW-1:0]         wr_idata_o,
    output logic [NREG-1:0]       busy_o
);

    localparam int         PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

    logic [PW-1:0]    last_grant_r;
    logic             we_r;
    logic [AW-1:0]    waddr_r;
    logic [DW-1:0]    wdata_r;
    logic [NREG-1:0]  busy_r;

    logic [PW:0]      sum_s;
    logic [PW:0]      cand_s;
    logic             found_s;
    logic [PW-1:0]    win_idx_s;
    logic [N_REQ-1:0] grant_s;
    logic             transfer_s;
    logic [AW-1:0]    win_addr_s;
    logic [DW-1:0]    win_data_s;
    logic [NREG-1:0]  set_mask_s;
    logic [NREG-1:0]  clr_mask_s;
    logic [NREG-1:0]  busy_nxt_s;

    // Round-robin search: scan from the requester after the last winner and stop at the first valid one.
    always_comb begin
        sum_s     = '0;
        cand_s    = '0;
        found_s   = 1'b0;
        win_idx_s = last_grant_r;
        for (int i = 1; i <= N_REQ; i++) begin
            sum_s  = {1'b0, last_grant_r} + (PW+1)'(i);
            cand_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            if (!found_s && req_valid_i[cand_s[PW-1:0]]) begin
                found_s   = 1'b1;
                win_idx_s = cand_s[PW-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot grant. It is suppressed while reset or flush is active, so nothing is accepted then.
    always_comb begin
        grant_s = '0;
        if (rst_i || flush_i) begin
            grant_s = '0;
        end else if (found_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign transfer_s  = |grant_s;
    assign req_ready_o = grant_s;

    // Select the winner's address and data. The grant is one-hot, so an AND-OR mux is enough.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win_addr_s = win_addr_s | ({AW{grant_s[k]}} & req_addr_i[k*AW +: AW]);
            win_data_s = win_data_s | ({DW{grant_s[k]}} & req_data_i[k*DW +: DW]);
        end
    end

    // Scoreboard update. An issue beats a same-edge writeback, flush beats both, and x0 is never busy.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (transfer_s) begin
            clr_mask_s[win_addr_s] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            set_mask_s[issue_rd_i] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (flush_i) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register the write port. A write to x0 completes its handshake but never asserts the enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r    <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else if (transfer_s) begin
            we_r    <= (win_addr_s != '0);
            waddr_r <= win_addr_s;
            wdata_r <= win_data_s;
        end else begin
            we_r    <= 1'b0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    // Arbitration pointer and busy scoreboard. Flush leaves the pointer alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_r <= LAST_REQ;
            busy_r       <= '0;
        end else begin
            last_grant_r <= transfer_s ? win_idx_s : last_grant_r;
            busy_r       <= busy_nxt_s;
        end
    end

    assign we_o       = we_r;
    assign w_iaddr_o  = waddr_r;
    assign wr_idata_o = wdata_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_mgt_01_i_wb_arbiter.sv
// Directed and short random bench for the writeback arbiter.
// A small reference model predicts the grant, the registered write and the
// busy vector every cycle. Predictions are queued when a cycle is driven and
// checked after the clock edge.
module tb_mgt_01_i_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [AW-1:0]   a_arr [N];
    logic [DW-1:0]   d_arr [N];
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic            issue_valid_i = 1'b0;
    logic [AW-1:0]   issue_rd_i = '0;
    logic            we_o;
    logic [AW-1:0]   w_iaddr_o;
    logic [DW-1:0]   wr_idata_o;
    logic [31:0]     busy_o;

    assign req_addr_i = {a_arr[2], a_arr[1], a_arr[0]};
    assign req_data_i = {d_arr[2], d_arr[1], d_arr[0]};

    mgt_01_i_wb_arbiter #(.N_REQ(N), .NREG(32), .DW(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .we_o(we_o), .w_iaddr_o(w_iaddr_o), .wr_idata_o(wr_idata_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] busy;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          m_ptr = N - 1;
    logic        m_we = 1'b0;
    logic [4:0]  m_a = '0;
    logic [31:0] m_d = '0;
    logic [31:0] m_busy = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
        a_arr[k[1:0]] = a;
        d_arr[k[1:0]] = d;
    endtask

    // One cycle: predict and check the grant, queue the post-edge prediction, then check it after the edge.
    task automatic tick();
        int          w;
        int          c;
        logic [2:0]  exp_rdy;
        logic [4:0]  wa;
        logic [31:0] nb;
        exp_t        e;
        @(negedge clk_i);
        w = -1;
        if (!rst_i && !flush_i) begin
            for (int i = 1; i <= N; i++) begin
                c = (m_ptr + i) % N;
                if (w < 0 && req_valid_i[c[1:0]]) w = c;
            end
        end
        exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
        chk("ready", 64'(req_ready_o), 64'(exp_rdy));
        nb = m_busy;
        if (rst_i) begin
            m_we = 1'b0; m_a = '0; m_d = '0; nb = '0; m_ptr = N - 1;
        end else begin
            if (w >= 0) begin
                wa = a_arr[w[1:0]];
                m_we = (wa != 5'd0);
                m_a = wa;
                m_d = d_arr[w[1:0]];
                nb[wa] = 1'b0;
                m_ptr = w;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid_i && issue_rd_i != 5'd0) nb[issue_rd_i] = 1'b1;
            if (flush_i) nb = '0;
        end
        m_busy = nb;
        e = '{m_we, m_a, m_d, nb};
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        chk("we", 64'(we_o), 64'(e.we));
        chk("waddr", 64'(w_iaddr_o), 64'(e.a));
        chk("wdata", 64'(wr_idata_o), 64'(e.d));
        chk("busy", 64'(busy_o), 64'(e.busy));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin a_arr[k] = '0; d_arr[k] = '0; end

        // Reset
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // Three requesters in parallel: grants 0,1,2 back to back
        set_req(0, 5'd1, 32'hA1A1_0001);
        set_req(1, 5'd2, 32'hB2B2_0002);
        set_req(2, 5'd3, 32'hC3C3_0003);
        req_valid_i = 3'b111;
        tick();
        tick();
        tick();
        chk("b2b_last_addr", 64'(w_iaddr_o), 64'd3);

        // Round-robin order after a grant to requester 1
        req_valid_i = 3'b010;
        tick();
        req_valid_i = 3'b011;
        tick();
        req_valid_i = 3'b010;
        tick();
        req_valid_i = 3'b000;
        tick();

        // Issue x5, then ALU writes x5
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        tick();
        issue_valid_i = 1'b0;
        chk("busy5_set", 64'(busy_o[5]), 64'd1);
        tick();
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        req_valid_i = 3'b001;
        tick();
        req_valid_i = 3'b000;
        chk("busy5_clr", 64'(busy_o[5]), 64'd0);
        chk("deadbeef", 64'(wr_idata_o), 64'hDEAD_BEEF);

        // Same-edge issue and writeback to x7; then x0 cases
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        set_req(0, 5'd7, 32'h0000_0077);
        req_valid_i = 3'b001;
        tick();
        chk("busy7_set_wins", 64'(busy_o[7]), 64'd1);
        issue_rd_i = 5'd0;
        set_req(0, 5'd0, 32'h0000_0099);
        tick();
        chk("x0_no_we", 64'(we_o), 64'd0);
        issue_valid_i = 1'b0;
        req_valid_i = 3'b000;

        // Busy x3 and x9, a pending write, then a flush with a competing issue
        issue_valid_i = 1'b1; issue_rd_i = 5'd3;
        tick();
        issue_rd_i = 5'd9;
        set_req(1, 5'd4, 32'h0000_0044);
        req_valid_i = 3'b010;
        tick();
        flush_i = 1'b1;
        issue_rd_i = 5'd12;
        set_req(0, 5'd8, 32'h0000_0088);
        req_valid_i = 3'b001;
        chk("flush_pending_we", 64'(we_o), 64'd1);
        tick();
        flush_i = 1'b0;
        issue_valid_i = 1'b0;

        // Reset while a transfer is in flight
        issue_valid_i = 1'b1; issue_rd_i = 5'd6;
        set_req(1, 5'd10, 32'h1010_1010);
        set_req(2, 5'd11, 32'h1111_1111);
        req_valid_i = 3'b110;
        tick();
        issue_valid_i = 1'b0;
        rst_i = 1'b1;
        req_valid_i = 3'b111;
        tick();
        rst_i = 1'b0;
        tick();
        chk("post_reset_winner", 64'(w_iaddr_o), 64'(a_arr[0]));

        // Short random traffic
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N; k++) set_req(k, 5'($urandom_range(0, 31)), $urandom);
            req_valid_i = 3'($urandom_range(0, 7));
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_rd_i = 5'($urandom_range(0, 31));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mgt_01_i_wb_arbiter.md
MGT_01_I_WB_ARBITER -- requirements
Module: MGT_01_i_wb_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, giving the number of writeback requesters (0 ALU, 1 MUL, 2 DIV/LSU).
REQ-002 The block SHALL have parameter NREG, default 32, giving the number of integer registers tracked.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
  clk_i  in  1  clock, all state on posedge
  rst_i  in  1  synchronous active-high reset
  flush_i  in  1  pipeline flush
  req_valid_i  in  N_REQ  writeback request valid, one bit per requester
  req_addr_i  in  N_REQ x i_register_e  destination register per requester
  req_data_i  in  N_REQ x data_bus_t  result per requester
  req_ready_o  out  N_REQ  grant / accept, one-hot or zero
  issue_valid_i  in  1  instruction with integer destination issued
  issue_rd_i  in  i_register_e  destination of issued instruction
  we_o  out  1  register file write enable
  w_iaddr_o  out  i_register_e  register file write address
  wr_idata_o  out  data_bus_t  register file write data
  busy_o  out  NREG  pending-write scoreboard, bit k = xk awaited

Function
REQ-005 A request k SHALL transfer in a cycle when req_valid_i[k] and req_ready_o[k] are both 1.
REQ-006 req_ready_o SHALL be combinational from req_valid_i, the round-robin pointer, rst_i and flush_i; at most one bit is high.
REQ-007 Arbitration SHALL be round-robin: search starts at requester (last_grant+1) mod N_REQ and the first valid requester wins.
REQ-008 The pointer last_grant SHALL update to the winner on each transfer and hold otherwise.
REQ-009 req_ready_o SHALL be all-zero while rst_i or flush_i is 1.
REQ-010 A requester SHALL hold valid, addr and data stable until accepted; the block does not buffer unaccepted requests.
REQ-011 Write output SHALL be registered: a transfer in cycle n drives we_o=1, w_iaddr_o=addr, wr_idata_o=data in cycle n+1 (latency 1).
REQ-012 In a cycle with no transfer, we_o SHALL be 0 next cycle; w_iaddr_o and wr_idata_o hold their last values.
REQ-013 A transfer with addr X0 SHALL complete the handshake but SHALL produce we_o=0.
REQ-014 Throughput SHALL be one write per cycle with no bubble between back-to-back transfers.
REQ-015 busy_o SHALL be registered: on a posedge with issue_valid_i=1 and issue_rd_i != X0, busy[issue_rd_i] sets.
REQ-016 On a posedge at which a transfer occurs, busy[addr] SHALL clear.
REQ-017 When a set and a clear hit the same register on one edge, the set SHALL win.
REQ-018 busy_o[0] SHALL be constantly 0.
REQ-019 flush_i=1 SHALL clear all busy bits at the next edge and SHALL take priority over a simultaneous issue.
REQ-020 flush_i SHALL NOT cancel a write already registered on we_o; that write completes.
REQ-021 last_grant SHALL be unchanged by flush_i.

Reset
REQ-022 While rst_i=1 at a posedge, the block SHALL set we_o=0, w_iaddr_o=X0, wr_idata_o=0, busy_o=0, and last_grant=N_REQ-1, so requester 0 has first priority.
REQ-023 Reset asserted mid-operation SHALL discard the registered write (we_o=0 next cycle) and SHALL accept no request during the reset cycle.

Verification
REQ-024 Reset, then valid=3'b111 with addrs x1,x2,x3 held for 3 cycles -> grants 0,1,2 on consecutive cycles; we_o=1 in cycles 2-4 with addrs x1,x2,x3.
REQ-025 After grant to requester 1, valid=3'b011 -> requester 0 granted next; then valid=3'b010 -> requester 1 granted.
REQ-026 issue x5 at cycle n -> busy_o[5]=1 from n+1; ALU writes x5 with data 0xDEADBEEF at n+2 -> we_o=1, wr_idata_o=0xDEADBEEF at n+3; busy_o[5]=0 from n+3.
REQ-027 Same edge: issue x7 and transfer to x7 -> busy_o[7]=1 afterwards; issue x0 -> busy_o[0] stays 0; write to x0 -> handshake completes, we_o=0.
REQ-028 Busy bits x3 and x9 set, flush_i=1 with valid=3'b001 and a write pending on we_o -> ready=0, the pending we_o write still appears, busy_o=0 next cycle.
REQ-029 Assert rst_i while a transfer is in flight -> we_o=0 next cycle, busy_o=0, and requester 0 wins the first post-reset arbitration.
